// File: rtl/mux_sel_pkg.sv
// Shared encodings for the selector arbiter: FSM states and sel values.
// Pure definitions, no logic.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/sel_hold_cnt.sv
// Grant hold counter: clear/enable, saturating, terminal flag at MAX_HOLD-1.
// Latency: count visible one cycle after enable; no backpressure.
module sel_hold_cnt #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = (cnt == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/mux_sel_arb.sv
// Round-robin arbiter for two requesters driving the 2:1 selector sel line; hold timeout under MUX_SEL_ARB_HOLD_LIMIT_EN.
// Latency: grant registered one cycle after the request is sampled; all outputs registered.
// Backpressure: owner keeps the path while req is high; release hands over with no idle bubble.
module mux_sel_arb
    import mux_sel_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             busy,
    output logic             switch_p,
    output logic [CNT_W-1:0] hold_cnt
);

`ifdef MUX_SEL_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_LIMIT = 1'b1;
`else
    localparam bit HOLD_LIMIT = 1'b0;
`endif

    state_t state_q, state_nxt;
    logic   ptr_q, ptr_nxt;
    logic   sel_nxt;
    logic   cnt_clr;
    logic   cnt_term;
    logic   timeout;

    // Timeout only matters under contention, so both reqs must be high.
    assign timeout = HOLD_LIMIT && req_a && req_b && cnt_term;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_a && (!req_b || ptr_q == SEL_A)) state_nxt = ST_GNT_A;
                else if (req_b)                          state_nxt = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (req_a && !timeout) state_nxt = ST_GNT_A;
                else if (req_b)        state_nxt = ST_GNT_B;
                else                   state_nxt = ST_IDLE;
            end
            ST_GNT_B: begin
                if (req_b && !timeout) state_nxt = ST_GNT_B;
                else if (req_a)        state_nxt = ST_GNT_A;
                else                   state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt = ptr_q;
        sel_nxt = sel;
        if (state_nxt == ST_GNT_A) begin
            sel_nxt = SEL_A;
            if (state_q != ST_GNT_A) ptr_nxt = SEL_B;
        end else if (state_nxt == ST_GNT_B) begin
            sel_nxt = SEL_B;
            if (state_q != ST_GNT_B) ptr_nxt = SEL_A;
        end
    end

    assign cnt_clr = (state_nxt != state_q) || (state_nxt == ST_IDLE);

    sel_hold_cnt #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (!cnt_clr),
        .cnt   (hold_cnt),
        .term  (cnt_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= SEL_A;
            sel      <= SEL_A;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            busy     <= 1'b0;
            switch_p <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ptr_q    <= ptr_nxt;
            sel      <= sel_nxt;
            gnt_a    <= (state_nxt == ST_GNT_A);
            gnt_b    <= (state_nxt == ST_GNT_B);
            busy     <= (state_nxt != ST_IDLE);
            switch_p <= (sel_nxt != sel);
        end
    end

endmodule

// File: tb/tb_mux_sel_arb.sv
// Self-checking bench for mux_sel_arb; expectations queued at stimulus time and popped at output.
module tb_mux_sel_arb;

    localparam int CNT_W = 8;
    localparam int MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_a, req_b;
    logic             gnt_a, gnt_b, sel, busy, switch_p;
    logic [CNT_W-1:0] hold_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       gb;
        logic       sw;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    logic grant_q[$];

    mux_sel_arb #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .sel      (sel),
        .busy     (busy),
        .switch_p (switch_p),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({gnt_a, gnt_b, sel, busy, switch_p, hold_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d got ga=%b gb=%b sel=%b busy=%b sw=%b cnt=%0d want all 0",
                         i, gnt_a, gnt_b, sel, busy, switch_p, hold_cnt);
            end
        end
        #3 rst_n = 1'b1;
        step();
        n_tests++;
        if ({gnt_a, gnt_b, sel, busy, switch_p} !== 5'b10010) begin
            n_fail++;
            $display("FAIL reset_first_grant got ga=%b gb=%b sel=%b busy=%b sw=%b want 1 0 0 1 0",
                     gnt_a, gnt_b, sel, busy, switch_p);
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got busy=%b want 0", busy);
        end
    endtask

    task automatic test_single();
        exp_t e;
        req_b = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back('{gb: 1'b1, sw: (i == 0), cnt: 8'(i)});
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 4) req_b = 1'b0;
            e = exp_q.pop_front();
            n_tests++;
            if (gnt_b !== e.gb || gnt_a !== 1'b0 || sel !== 1'b1 || switch_p !== e.sw || hold_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL single_b cyc%0d got ga=%b gb=%b sel=%b sw=%b cnt=%0d want ga=0 gb=1 sel=1 sw=%b cnt=%0d",
                         i, gnt_a, gnt_b, sel, switch_p, hold_cnt, e.sw, e.cnt);
            end
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || sel !== 1'b1 || switch_p !== 1'b0 || hold_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL single_idle got busy=%b sel=%b sw=%b cnt=%0d want busy=0 sel=1 sw=0 cnt=0",
                     busy, sel, switch_p, hold_cnt);
        end
    endtask

    task automatic test_pulse();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        n_tests++;
        if (gnt_a !== 1'b1 || sel !== 1'b0 || switch_p !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_grant got ga=%b sel=%b sw=%b want 1 0 1", gnt_a, sel, switch_p);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || gnt_a !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_release got busy=%b ga=%b want 0 0", busy, gnt_a);
        end
    endtask

    task automatic test_handover();
        req_a = 1'b1;
        step();
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL handover_hold_a cyc%0d got ga=%b gb=%b busy=%b want 1 0 1", i, gnt_a, gnt_b, busy);
            end
        end
        req_a = 1'b0;
        step();
        n_tests++;
        if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || sel !== 1'b1 || busy !== 1'b1 || switch_p !== 1'b1 || hold_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL handover_to_b got ga=%b gb=%b sel=%b busy=%b sw=%b cnt=%0d want 0 1 1 1 1 0",
                     gnt_a, gnt_b, sel, busy, switch_p, hold_cnt);
        end
        req_b = 1'b0;
        step();
    endtask

    task automatic test_fair();
        logic prev_busy;
        logic want_b;
        prev_busy = busy;
        for (int r = 0; r < 4; r++) begin
            grant_q.push_back(r[0]);
            req_a = 1'b1; req_b = 1'b1;
            for (int c = 0; c < 3; c++) begin
                step();
                if (c == 1) begin req_a = 1'b0; req_b = 1'b0; end
                n_tests++;
                if (gnt_a && gnt_b) begin
                    n_fail++;
                    $display("FAIL fair_mutex r%0d c%0d got ga=1 gb=1 want at most one", r, c);
                end
                if (busy && !prev_busy) begin
                    want_b = (grant_q.size() > 0) ? grant_q.pop_front() : 1'bx;
                    n_tests++;
                    if (gnt_b !== want_b) begin
                        n_fail++;
                        $display("FAIL fair_order r%0d got gb=%b want gb=%b", r, gnt_b, want_b);
                    end
                end
                prev_busy = busy;
            end
        end
        n_tests++;
        if (grant_q.size() != 0) begin
            n_fail++;
            $display("FAIL fair_count got %0d grants missing want 0", grant_q.size());
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 24; i++) begin
`ifdef MUX_SEL_ARB_HOLD_LIMIT_EN
            exp_q.push_back('{gb: ((i / MAX_HOLD) % 2 == 1), sw: (i % MAX_HOLD == 0), cnt: 8'(i % MAX_HOLD)});
`else
            exp_q.push_back('{gb: 1'b0, sw: (i == 0), cnt: 8'(i)});
`endif
        end
        for (int i = 0; i < 24; i++) begin
            step();
            e = exp_q.pop_front();
            n_tests++;
            if (gnt_b !== e.gb || gnt_a !== !e.gb || sel !== e.gb || switch_p !== e.sw || hold_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL timeout cyc%0d got ga=%b gb=%b sel=%b sw=%b cnt=%0d want gb=%b sel=%b sw=%b cnt=%0d",
                         i, gnt_a, gnt_b, sel, switch_p, hold_cnt, e.gb, e.gb, e.sw, e.cnt);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        req_b = 1'b1;
        step();
        n_tests++;
        if (gnt_b !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup got gb=%b want 1", gnt_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (gnt_b !== 1'b0 || sel !== 1'b0 || busy !== 1'b0 || hold_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_async got gb=%b sel=%b busy=%b cnt=%0d want 0 0 0 0", gnt_b, sel, busy, hold_cnt);
        end
        req_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || sel !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after got busy=%b sel=%b want 0 0", busy, sel);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        test_reset();
        test_single();
        test_pulse();
        test_handover();
        test_fair();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_arb.md
Name: mux_sel_arb

Overview:
- Round-robin arbiter sitting directly upstream of the 2:1 selector (fn_sw).
- Two requesters (A, B) compete for the shared selector output path.
- The block grants one requester at a time and drives the selector's sel line: 0 selects a, 1 selects b.
- Provides grant handshake, fair alternation under contention, and an optional maximum-hold timeout.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant while the other waits (used only with the timeout feature); legal range 2..255.
- CNT_W, 8, width of hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A wants the path; held high for the whole transaction.
- req_b  input  1  requester B wants the path; held high for the whole transaction.
- gnt_a  output  1  A owns the path.
- gnt_b  output  1  B owns the path.
- sel  output  1  selector control to fn_sw; 0 = a, 1 = b.
- busy  output  1  gnt_a | gnt_b.
- switch_p  output  1  one-cycle pulse on the cycle sel changes value.
- hold_cnt  output  CNT_W  cycles the current grant has been held, for debug.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE, gnt_a=0, gnt_b=0, sel=0, busy=0, switch_p=0, hold_cnt=0, priority pointer=A.
- Deassertion of rst_n takes effect at the next clk edge.
- All outputs are registered; there is no combinational path from req to any output.
- States are IDLE, GNT_A and GNT_B.
- From IDLE:
  - Only req_a high -> GNT_A.
  - Only req_b high -> GNT_B.
  - Both high -> the requester named by the priority pointer.
  - Neither high -> stay in IDLE.
- Grant latency: a request sampled at edge N produces the grant at edge N+1, so grant is visible 1 cycle after request.
- In GNT_A (GNT_B is symmetric):
  - req_a stays high and no timeout -> stay, hold_cnt increments, saturating at 2**CNT_W-1.
  - req_a drops and req_b high -> GNT_B directly, with no IDLE bubble.
  - req_a drops and req_b low -> IDLE.
- Priority pointer:
  - Updated on every grant entry to point at the other requester.
  - Both requesters therefore alternate under continuous contention.
- hold_cnt:
  - Cleared to 0 on entry to any grant state and in IDLE.
  - Equals 0 on the first granted cycle.
- sel:
  - 0 in GNT_A, 1 in GNT_B.
  - Retains its last value in IDLE so the selector does not glitch.
  - switch_p=1 on exactly the cycle the registered sel differs from its previous value.
- gnt_a and gnt_b are mutually exclusive at all times.
- Requester protocol: a requester drops req only after seeing its grant. A req pulse that ends before its grant is allowed; the grant is then given for 1 cycle and released on the next evaluation.
- Simultaneous release of the owner and rise of the other requester on the same edge -> direct handover to the other requester.
- Reset asserted mid-grant -> immediate return to reset values; the in-flight transaction is dropped.

Optional Feature:
- Macro: MUX_SEL_ARB_HOLD_LIMIT_EN.
- Defined:
  - In GNT_A with req_a high, req_b high and hold_cnt == MAX_HOLD-1 -> forced move to GNT_B at the next edge; gnt_a drops.
  - A re-competes by keeping req_a high and is regranted through the normal rules.
  - No timeout occurs when the other requester is idle.
  - GNT_B is symmetric.
- Undefined:
  - The owner holds the grant indefinitely while its req is high.
  - MAX_HOLD is ignored.

Decomposition:
- Shared package mux_sel_pkg holds:
  - State encoding localparams ST_IDLE=2'd0, ST_GNT_A=2'd1, ST_GNT_B=2'd2.
  - Selector encodings SEL_A=1'b0, SEL_B=1'b1.
- One sub-module, sel_hold_cnt: clear, enable, saturating counter, and terminal flag hold_cnt==MAX_HOLD-1.
- The FSM, pointer and output registers stay in mux_sel_arb.

Test Plan:
- Reset sequence:
  - Stimulus: rst_n low for 3 cycles with req_a=1, req_b=1.
  - Required: all outputs 0 during reset.
  - Required: gnt_a=1, sel=0 one cycle after rst_n rises, because the pointer starts at A.
- Single requester:
  - Stimulus: req_b high for 5 cycles, then low.
  - Required: gnt_b=1, sel=1 and switch_p=1 at cycle 1.
  - Required: hold_cnt runs 0..4.
  - Required: IDLE one cycle after release, with sel held at 1 and switch_p=0.
- Handover:
  - Stimulus: A owns the grant, req_b rises, req_a drops 4 cycles later.
  - Required: gnt_b=1 and sel=1 on the very next edge after req_a falls, with no cycle where busy=0.
- Fair alternation:
  - Stimulus: both requesters each repeatedly request for 2 cycles then release for 1.
  - Required: grants alternate A, B, A, B; gnt_a and gnt_b never both 1.
- Timeout, with MUX_SEL_ARB_HOLD_LIMIT_EN defined and MAX_HOLD=8:
  - Stimulus: req_a and req_b held high continuously.
  - Required: A is granted for exactly 8 cycles, then B for 8 cycles, and so on.
  - Required: switch_p pulses every 8 cycles.
  - Without the macro, A holds the grant indefinitely.
- Reset mid-grant:
  - Stimulus: rst_n is pulled low between clock edges while gnt_b=1.
  - Required: gnt_b=0 and sel=0 immediately, without waiting for clk.
